alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue controller that drives the ALU's func/dataIn1/dataIn2 inputs and consumes its dataOut/compTrue outputs.
- Fetches one instruction per handshake, decodes it into an ALU function code and operands, and samples the ALU result.
- Writes the register file and steers the PC, including the branch decision from compTrue.
- Sits between instruction memory, the register file and the ALU.

Parameters:
- DBITS, 32, data and PC width.
- RESET_PC, 32'h0000_0040, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instrValid  in  1  instruction word available.
- instrReady  out  1  controller accepts instruction this cycle.
- instr  in  32  instruction word.
- pc  out  DBITS  address of the current instruction.
- rs1Idx  out  4  register file read index 1.
- rs2Idx  out  4  register file read index 2.
- rs1Data  in  DBITS  combinational read data for rs1Idx.
- rs2Data  in  DBITS  combinational read data for rs2Idx.
- aluFunc  out  5  ALU function code.
- aluIn1  out  DBITS  ALU operand 1.
- aluIn2  out  DBITS  ALU operand 2.
- aluOut  in  DBITS  ALU result.
- aluCompTrue  in  1  ALU comparison result.
- regWrEn  out  1  register write strobe, one cycle.
- regWrIdx  out  4  write index.
- regWrData  out  DBITS  write data.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Instruction fields:
  - op = instr[31:28], rd = instr[27:24], rs1 = instr[23:20], rs2 = instr[19:16], imm = instr[15:0].
  - simm = sign-extended imm to DBITS.
- FSM states: FETCH, DECODE, EXEC, WB. Transitions:
  - FETCH -> DECODE when instrValid is high; otherwise hold.
  - DECODE -> EXEC, EXEC -> WB, WB -> FETCH unconditionally.
  - Minimum 4 cycles per instruction.
- FETCH:
  - instrReady = 1; all other strobes are 0.
  - The instruction register latches instr on the cycle where instrValid & instrReady.
- DECODE:
  - rs1Idx and rs2Idx are driven from the latched fields and stay stable through WB.
  - Operands and func are registered at the end of DECODE.
- EXEC: aluFunc/aluIn1/aluIn2 are driven from registers; aluOut and aluCompTrue are sampled at the end of EXEC.
- Opcode decode:
  - 0x0 ALUR: func = imm[4:0], in1 = rs1Data, in2 = rs2Data; rd <= aluOut.
  - 0x1 ADDI: func = 5'b00000, in1 = rs1Data, in2 = simm; rd <= aluOut.
  - 0x2 BR: func = {1'b1, instr[27:24]}, in1 = rs1Data, in2 = rs2Data; no register write.
    - If compTrue, pc <= pc + 4 + (simm << 2); else pc <= pc + 4.
  - 0x3 JAL: func = 5'b00000, in1 = rs1Data, in2 = simm; rd <= pc + 4; pc <= aluOut with bits [1:0] forced to 0.
  - Any other op: no register write, pc <= pc + 4, illegal pulses during WB.
- WB:
  - regWrEn = 1 for exactly one cycle for ALUR, ADDI and JAL.
  - regWrIdx/regWrData are valid in that same cycle.
  - pc updates on the WB -> FETCH edge.
- Arithmetic: PC arithmetic is modulo 2^DBITS and wraps silently. Example: pc 32'hFFFF_FFFC + 4 -> 0.
- The controller does not filter rd = 0; the register file handles r0.
- Outputs while in FETCH, and their reset values:
  - pc = RESET_PC; all other outputs 0, except instrReady.
  - instrReady = 1 as soon as reset deasserts, because the FSM resets to FETCH.
- Reset asserted in any state:
  - Immediately returns to FETCH and reloads pc = RESET_PC.
  - Clears the latched instruction; no pending write or PC update survives.
- instrValid while not in FETCH is ignored; instrReady is 0 in those states.

Test Plan:
- Reset released, instrValid = 0 for 5 cycles -> pc = 0x40, instrReady = 1, regWrEn never asserts.
- ALUR add: rs1Data = 2, rs2Data = 3, imm[4:0] = 00000, rd = 5 -> aluFunc = 0 in EXEC, and in WB regWrEn = 1, regWrIdx = 5, regWrData = 5; pc = 0x44 after WB.
- ADDI: rs1Data = -2, imm = 16'h0003 -> regWrData = 1. ADDI with imm = 16'hFFFF and rs1Data = 0 -> regWrData = 32'hFFFF_FFFF.
- BR with func 10001, pc = 0x40, imm = 2:
  - rs1Data = rs2Data = 2, aluCompTrue = 1 -> pc = 0x4C, no regWrEn.
  - rs2Data = 3, aluCompTrue = 0 -> pc = 0x44.
- JAL: pc = 0x40, rs1Data = 0x100, imm = 6 -> rd written with 0x44, pc = 0x104; op = 0xF -> illegal pulses for 1 cycle, pc + 4, no write.
- Reset asserted in EXEC of an ALUR -> no regWrEn ever; pc = 0x40 and FETCH restarts on deassert.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Fetch/decode/execute/writeback sequencer that feeds the ALU and writes results back to the register file and PC.
// Four cycles per instruction minimum; instrReady is high only in FETCH, so a stalled instrValid simply holds FETCH.
module alu_issue_ctrl #(
  parameter int               DBITS    = 32,
  parameter logic [DBITS-1:0] RESET_PC = 32'h0000_0040
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instrValid,
  output logic             instrReady,
  input  logic [31:0]      instr,
  output logic [DBITS-1:0] pc,
  output logic [3:0]       rs1Idx,
  output logic [3:0]       rs2Idx,
  input  logic [DBITS-1:0] rs1Data,
  input  logic [DBITS-1:0] rs2Data,
  output logic [4:0]       aluFunc,
  output logic [DBITS-1:0] aluIn1,
  output logic [DBITS-1:0] aluIn2,
  input  logic [DBITS-1:0] aluOut,
  input  logic             aluCompTrue,
  output logic             regWrEn,
  output logic [3:0]       regWrIdx,
  output logic [DBITS-1:0] regWrData,
  output logic             illegal
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

  state_t           state_q, state_d;
  logic [31:0]      ir_q;
  logic [DBITS-1:0] pc_q, pc_d;
  logic [4:0]       func_q, func_d;
  logic [DBITS-1:0] in1_q, in2_q, in2_d;
  logic [DBITS-1:0] res_q;
  logic             comp_q;

  logic [3:0]       op, rd;
  logic [DBITS-1:0] simm, pc_plus4;
  logic             writes_rd;

  assign op       = ir_q[31:28];
  assign rd       = ir_q[27:24];
  assign simm     = {{(DBITS-16){ir_q[15]}}, ir_q[15:0]};
  assign pc_plus4 = pc_q + DBITS'(4);
  assign writes_rd = (op == 4'h0) || (op == 4'h1) || (op == 4'h3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  if (instrValid) state_d = DECODE;
      DECODE: state_d = EXEC;
      EXEC:   state_d = WB;
      WB:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    func_d = 5'd0;
    in2_d  = simm;
    unique case (op)
      4'h0: begin func_d = ir_q[4:0];       in2_d = rs2Data; end
      4'h2: begin func_d = {1'b1, rd};      in2_d = rs2Data; end
      default: ;
    endcase
  end

  // JAL targets are word aligned regardless of the low bits of the sum
  always_comb begin
    pc_d = pc_plus4;
    if (op == 4'h2 && comp_q) pc_d = pc_plus4 + (simm << 2);
    else if (op == 4'h3)      pc_d = res_q & ~DBITS'(3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q   <= '0;
      pc_q   <= RESET_PC;
      func_q <= '0;
      in1_q  <= '0;
      in2_q  <= '0;
      res_q  <= '0;
      comp_q <= 1'b0;
    end else begin
      if (state_q == FETCH && instrValid) ir_q <= instr;
      if (state_q == DECODE) begin
        func_q <= func_d;
        in1_q  <= rs1Data;
        in2_q  <= in2_d;
      end
      if (state_q == EXEC) begin
        res_q  <= aluOut;
        comp_q <= aluCompTrue;
      end
      if (state_q == WB) pc_q <= pc_d;
    end
  end

  always_comb begin
    pc         = pc_q;
    instrReady = 1'b0;
    rs1Idx     = 4'd0;
    rs2Idx     = 4'd0;
    aluFunc    = 5'd0;
    aluIn1     = '0;
    aluIn2     = '0;
    regWrEn    = 1'b0;
    regWrIdx   = 4'd0;
    regWrData  = '0;
    illegal    = 1'b0;
    if (state_q == FETCH) begin
      instrReady = 1'b1;
    end else begin
      rs1Idx = ir_q[23:20];
      rs2Idx = ir_q[19:16];
      if (state_q == EXEC) begin
        aluFunc = func_q;
        aluIn1  = in1_q;
        aluIn2  = in2_q;
      end
      if (state_q == WB) begin
        regWrEn   = writes_rd;
        regWrIdx  = writes_rd ? rd : 4'd0;
        regWrData = !writes_rd ? '0 : (op == 4'h3) ? pc_plus4 : res_q;
        illegal   = (op > 4'h3);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU answers the DUT, a reference model predicts each retirement.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrValid, instrReady;
  logic [31:0] instr, pc;
  logic [3:0]  rs1Idx, rs2Idx;
  logic [31:0] rs1Data, rs2Data;
  logic [4:0]  aluFunc;
  logic [31:0] aluIn1, aluIn2, aluOut;
  logic        aluCompTrue;
  logic        regWrEn;
  logic [3:0]  regWrIdx;
  logic [31:0] regWrData;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DBITS(32), .RESET_PC(32'h40)) dut (
    .clk(clk), .reset(reset),
    .instrValid(instrValid), .instrReady(instrReady), .instr(instr),
    .pc(pc), .rs1Idx(rs1Idx), .rs2Idx(rs2Idx),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .aluFunc(aluFunc), .aluIn1(aluIn1), .aluIn2(aluIn2),
    .aluOut(aluOut), .aluCompTrue(aluCompTrue),
    .regWrEn(regWrEn), .regWrIdx(regWrIdx), .regWrData(regWrData),
    .illegal(illegal)
  );

  // Small ALU: 0 add, 1 sub, 0x11 equal, 0x12 signed less-than
  function automatic logic [32:0] alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      5'h00:   return {1'b0, a + b};
      5'h01:   return {1'b0, a - b};
      5'h11:   return {a == b, 32'd0};
      5'h12:   return {$signed(a) < $signed(b), 32'd0};
      default: return 33'd0;
    endcase
  endfunction

  always_comb begin
    {aluCompTrue, aluOut} = alu(aluFunc, aluIn1, aluIn2);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  func;
    logic        chkf;
    logic        wr;
    logic [3:0]  idx;
    logic [31:0] data;
    logic        ill;
    logic [31:0] pcn;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] cur);
    exp_t        e;
    logic [31:0] simm;
    logic [32:0] r;
    simm  = {{16{ins[15]}}, ins[15:0]};
    e.func = 5'd0; e.chkf = 1'b1; e.wr = 1'b0; e.idx = ins[27:24]; e.data = 32'd0; e.ill = 1'b0;
    e.pcn  = cur + 32'd4;
    case (ins[31:28])
      4'h0: begin e.func = ins[4:0]; r = alu(ins[4:0], a, b); e.wr = 1'b1; e.data = r[31:0]; end
      4'h1: begin e.wr = 1'b1; e.data = a + simm; end
      4'h2: begin
        e.func = {1'b1, ins[27:24]};
        r = alu(e.func, a, b);
        if (r[32]) e.pcn = cur + 32'd4 + {simm[29:0], 2'b00};
      end
      4'h3: begin e.wr = 1'b1; e.data = cur + 32'd4; e.pcn = (a + simm) & 32'hFFFF_FFFC; end
      default: begin e.chkf = 1'b0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // Monitor: tracks one instruction from accept to the return of instrReady
  int          cnt = 0, sw = 0, si = 0, wr_total = 0;
  logic        prev_rdy = 1'b1;
  logic [4:0]  sf = 5'd0;
  logic [3:0]  sidx = 4'd0;
  logic [31:0] sdat = 32'd0;

  always @(negedge clk) begin
    if (reset) begin
      cnt = 0; sw = 0; si = 0; prev_rdy = 1'b1;
    end else begin
      if (regWrEn) wr_total++;
      if (!instrReady) begin
        cnt++;
        if (cnt == 2) sf = aluFunc;
        if (regWrEn) begin sw++; sidx = regWrIdx; sdat = regWrData; end
        if (illegal) si++;
      end else begin
        chk("fetch_quiet", {regWrEn, illegal, aluFunc, rs1Idx, rs2Idx, regWrIdx}, 0);
        if (!prev_rdy) begin
          if (sb.size() == 0) chk("spurious_retire", 1, 0);
          else begin
            exp_t e;
            e = sb.pop_front();
            if (e.chkf) chk("exec_func", sf, e.func);
            chk("wr_count", sw, e.wr);
            if (e.wr) begin
              chk("wr_idx", sidx, e.idx);
              chk("wr_data", sdat, e.data);
            end
            chk("illegal_count", si, e.ill);
            chk("pc_next", pc, e.pcn);
            chk("cycles", cnt, 3);
          end
          cnt = 0; sw = 0; si = 0;
        end
      end
      prev_rdy = instrReady;
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    instrValid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_pc = 32'h40;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int n;
    exp_t e;
    rs1Data = a; rs2Data = b; instr = ins; instrValid = 1'b1;
    e = model(ins, a, b, m_pc);
    m_pc = e.pcn;
    sb.push_back(e);
    n = 0;
    while (!instrReady && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    instrValid = 1'b0;
    instr = 32'hDEAD_BEEF;
    n = 0;
    while (!instrReady && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("retire_timeout", 0, 1);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] r1,
                                     input logic [3:0] r2, input logic [15:0] imm);
    return {op, rd, r1, r2, imm};
  endfunction

  initial begin
    int wr_before;
    reset = 1'b1; instrValid = 1'b0; instr = 32'd0; rs1Data = 32'd0; rs2Data = 32'd0;
    m_pc = 32'h40;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", instrReady, 1);
    chk("rst_pc", pc, 32'h40);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_pc", pc, 32'h40);
    chk("idle_ready", instrReady, 1);
    chk("idle_no_write", wr_total, 0);

    issue(mk(4'h0, 4'd5, 4'd1, 4'd2, 16'h0000), 32'd2, 32'd3);
    issue(mk(4'h1, 4'd6, 4'd1, 4'd0, 16'h0003), 32'hFFFF_FFFE, 32'd9);
    issue(mk(4'h1, 4'd7, 4'd0, 4'd0, 16'hFFFF), 32'd0, 32'd9);
    issue(mk(4'h0, 4'd0, 4'd3, 4'd4, 16'h0001), 32'd10, 32'd25);

    do_reset();
    issue(mk(4'h2, 4'h1, 4'd1, 4'd2, 16'd2), 32'd2, 32'd2);
    do_reset();
    issue(mk(4'h2, 4'h1, 4'd1, 4'd2, 16'd2), 32'd2, 32'd3);
    issue(mk(4'h2, 4'h2, 4'd1, 4'd2, 16'hFFFF), 32'hFFFF_FFF0, 32'd1);

    do_reset();
    issue(mk(4'h3, 4'd7, 4'd1, 4'd0, 16'd6), 32'h100, 32'd0);
    issue(mk(4'hF, 4'd8, 4'd1, 4'd2, 16'h1234), 32'd1, 32'd1);
    issue(mk(4'h3, 4'd9, 4'd2, 4'd0, 16'h000C), 32'hFFFF_FFF0, 32'd0);
    issue(mk(4'h1, 4'd3, 4'd2, 4'd0, 16'h0001), 32'd41, 32'd0);
    chk("pc_wrap", pc, 32'h0);

    // Abort an ALUR in EXEC: nothing may retire
    do_reset();
    wr_before = wr_total;
    rs1Data = 32'd4; rs2Data = 32'd5;
    instr = mk(4'h0, 4'd5, 4'd1, 4'd2, 16'h0000);
    instrValid = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_ready", instrReady, 1);
    chk("abort_pc", pc, 32'h40);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_pc = 32'h40;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_write", wr_total, wr_before);
    chk("abort_pc_hold", pc, 32'h40);
    issue(mk(4'h1, 4'd2, 4'd1, 4'd0, 16'h0010), 32'd1, 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
